// File: rtl/ula_sequenciador_pkg.sv
// ula_pkg: shared definitions for the ULA operand/control stage.
//   - FUNC_* : ULA function codes driven on ula_func
//   - state_t: sequencer FSM encoding (IDLE=0, EXEC=1, WB=2)
//   - is_arith(): true for the codes whose result can carry signed overflow
package ula_pkg;

  localparam logic [2:0] FUNC_ADD   = 3'b000;
  localparam logic [2:0] FUNC_SUB   = 3'b001;
  localparam logic [2:0] FUNC_AND   = 3'b010;
  localparam logic [2:0] FUNC_OR    = 3'b011;
  localparam logic [2:0] FUNC_XNOR  = 3'b100;
  localparam logic [2:0] FUNC_NOTA  = 3'b101;
  localparam logic [2:0] FUNC_PASSA = 3'b110;
  localparam logic [2:0] FUNC_NOTB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [2:0] func);
    return (func == FUNC_ADD) || (func == FUNC_SUB);
  endfunction

endpackage

// File: rtl/ula_sequenciador_if.sv
// Request bus of the ULA sequencer (valid/ready handshake).
//   master: requester drives req_valid/req_load/req_func/req_rd/req_rs1/req_rs2/req_imm,
//           samples req_ready
//   slave : sequencer side
interface ula_sequenciador_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic [2:0]        req_func;
  logic [ADDR_W-1:0] req_rd;
  logic [ADDR_W-1:0] req_rs1;
  logic [ADDR_W-1:0] req_rs2;
  logic [DATA_W-1:0] req_imm;

  modport master (
    output req_valid, req_load, req_func, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_load, req_func, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready
  );
endinterface

// File: rtl/ula_sequenciador_banco_registradores.sv
// banco_registradores: NREGS x DATA_W register file.
//   clk, rst_n : clock, synchronous active-low clear of every register
//   ra1/rd1, ra2/rd2 : two combinational read ports
//   we, wa, wd : synchronous write port
// Register 0 always reads zero and ignores writes.
module banco_registradores #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/ula_sequenciador.sv
// ula_sequenciador: operand/control stage in front of a combinational 32-bit ULA.
//   clk, rst_n        : clock, synchronous active-low reset
//   req (slave)       : one request at a time; req_ready is high only in IDLE
//   ula_A/ula_B/func  : registered operands/function to the ULA, change only on op acceptance
//   ula_R, ula_pinV   : ULA result and signed-overflow flag, captured at the end of EXEC
//   done              : one-cycle pulse on write-back completion
//   res_out, flag_Z/N/V : last written value and its flags, held until the next write-back
// Optional build macro ULA_STATS_EN adds saturating op_count/ovf_count outputs.
module ula_sequenciador
  import ula_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ula_sequenciador_if.slave req,
  output logic [DATA_W-1:0] ula_A,
  output logic [DATA_W-1:0] ula_B,
  output logic [2:0]        ula_func,
  input  logic [DATA_W-1:0] ula_R,
  input  logic              ula_pinV,
  output logic              done,
  output logic [DATA_W-1:0] res_out,
  output logic              flag_Z,
  output logic              flag_N,
  output logic              flag_V
`ifdef ULA_STATS_EN
  ,
  output logic [15:0]       op_count,
  output logic [15:0]       ovf_count
`endif
);

  localparam int ADDR_W = $clog2(NREGS);

  state_t state, state_next;

  logic [ADDR_W-1:0] rd_p0;
  logic              load_p0;
  logic [DATA_W-1:0] result_p1;
  logic              pinv_p1;
  logic [DATA_W-1:0] rd1, rd2;
  logic              v_wb;

  banco_registradores #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_banco (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (req.req_rs1),
    .ra2   (req.req_rs2),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (state == WB),
    .wa    (rd_p0),
    .wd    (result_p1)
  );

  // Overflow is only meaningful for ADD/SUB; loads never report it.
  assign v_wb = !load_p0 && is_arith(ula_func) && pinv_p1;

  always_comb begin
    state_next    = state;
    req.req_ready = 1'b0;
    case (state)
      IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid) state_next = req.req_load ? WB : EXEC;
      end
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ula_A     <= '0;
      ula_B     <= '0;
      ula_func  <= '0;
      rd_p0     <= '0;
      load_p0   <= 1'b0;
      result_p1 <= '0;
      pinv_p1   <= 1'b0;
      done      <= 1'b0;
      res_out   <= '0;
      flag_Z    <= 1'b0;
      flag_N    <= 1'b0;
      flag_V    <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        // p0: request capture
        IDLE: begin
          if (req.req_valid) begin
            rd_p0   <= req.req_rd;
            load_p0 <= req.req_load;
            if (req.req_load) begin
              result_p1 <= req.req_imm;
            end else begin
              ula_A    <= rd1;
              ula_B    <= rd2;
              ula_func <= req.req_func;
            end
          end
        end
        // p1: ULA result capture
        EXEC: begin
          result_p1 <= ula_R;
          pinv_p1   <= ula_pinV;
        end
        // p2: write-back; the register file write lands on this same edge
        WB: begin
          res_out <= result_p1;
          flag_Z  <= (result_p1 == '0);
          flag_N  <= result_p1[DATA_W-1];
          flag_V  <= v_wb;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ULA_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (state == WB) begin
      if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      if (v_wb && (ovf_count != 16'hFFFF)) ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed testbench for ula_sequenciador. A behavioural ULA drives ula_R/ula_pinV
// from the DUT operands; expected values are hand-computed constants.
// Build with +define+ULA_STATS_EN to also check the statistics counters.
module tb_ula_sequenciador;
  import ula_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ula_A, ula_B, ula_R, res_out;
  logic [2:0]  ula_func;
  logic        ula_pinV, done, flag_Z, flag_N, flag_V;
  logic        force_v;
  logic [31:0] ula_r_calc;
  logic        ula_v_calc;
`ifdef ULA_STATS_EN
  logic [15:0] op_count, ovf_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  ula_sequenciador_if #(.DATA_W(32), .ADDR_W(3)) rif ();

  ula_sequenciador #(.DATA_W(32), .NREGS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (rif.slave),
    .ula_A    (ula_A),
    .ula_B    (ula_B),
    .ula_func (ula_func),
    .ula_R    (ula_R),
    .ula_pinV (ula_pinV),
    .done     (done),
    .res_out  (res_out),
    .flag_Z   (flag_Z),
    .flag_N   (flag_N),
    .flag_V   (flag_V)
`ifdef ULA_STATS_EN
    ,
    .op_count (op_count),
    .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ULA
  always_comb begin
    ula_r_calc = '0;
    ula_v_calc = 1'b0;
    case (ula_func)
      FUNC_ADD: begin
        ula_r_calc = ula_A + ula_B;
        ula_v_calc = (ula_A[31] == ula_B[31]) && (ula_r_calc[31] != ula_A[31]);
      end
      FUNC_SUB: begin
        ula_r_calc = ula_A - ula_B;
        ula_v_calc = (ula_A[31] != ula_B[31]) && (ula_r_calc[31] != ula_A[31]);
      end
      FUNC_AND:   ula_r_calc = ula_A & ula_B;
      FUNC_OR:    ula_r_calc = ula_A | ula_B;
      FUNC_XNOR:  ula_r_calc = ~(ula_A ^ ula_B);
      FUNC_NOTA:  ula_r_calc = ~ula_A;
      FUNC_PASSA: ula_r_calc = ula_A;
      default:    ula_r_calc = ~ula_B;
    endcase
  end
  assign ula_R    = ula_r_calc;
  assign ula_pinV = ula_v_calc | force_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE; returns operands seen in the cycle after
  // acceptance and the number of edges until done (bounded).
  task automatic issue(input logic ld, input logic [2:0] f, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [31:0] imm,
                       output int lat, output logic [31:0] a_obs, output logic [31:0] b_obs);
    @(negedge clk);
    rif.req_load  = ld;
    rif.req_func  = f;
    rif.req_rd    = rd;
    rif.req_rs1   = rs1;
    rif.req_rs2   = rs2;
    rif.req_imm   = imm;
    rif.req_valid = 1'b1;
    @(posedge clk); #1;
    rif.req_valid = 1'b0;
    a_obs = ula_A;
    b_obs = ula_B;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int          lat, acc, dn;
  logic [31:0] a_o, b_o;

  initial begin
    rst_n = 1'b0;
    force_v = 1'b0;
    rif.req_valid = 1'b0;
    rif.req_load  = 1'b0;
    rif.req_func  = '0;
    rif.req_rd    = '0;
    rif.req_rs1   = '0;
    rif.req_rs2   = '0;
    rif.req_imm   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, rif.req_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", res_out, 32'd0);
    chk("rst_flags", {29'd0, flag_Z, flag_N, flag_V}, 32'd0);
    chk("rst_ulaA", ula_A, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ADD: 5 + 3
    issue(1'b1, FUNC_ADD, 3'd1, 3'd0, 3'd0, 32'd5, lat, a_o, b_o);
    chk("t1_load_lat", lat, 32'd1);
    chk("t1_load_res", res_out, 32'd5);
    issue(1'b1, FUNC_ADD, 3'd2, 3'd0, 3'd0, 32'd3, lat, a_o, b_o);
    issue(1'b0, FUNC_ADD, 3'd3, 3'd1, 3'd2, 32'd0, lat, a_o, b_o);
    chk("t1_exec_A", a_o, 32'd5);
    chk("t1_exec_B", b_o, 32'd3);
    chk("t1_op_lat", lat, 32'd2);
    chk("t1_res", res_out, 32'd8);
    chk("t1_ZNV", {29'd0, flag_Z, flag_N, flag_V}, 32'd0);
    @(posedge clk); #1;
    chk("t1_done_pulse", {31'd0, done}, 32'd0);

    // Signed overflow on ADD
    do_reset();
    issue(1'b1, FUNC_ADD, 3'd1, 3'd0, 3'd0, 32'h7FFF_FFFF, lat, a_o, b_o);
    issue(1'b1, FUNC_ADD, 3'd2, 3'd0, 3'd0, 32'd1, lat, a_o, b_o);
    issue(1'b0, FUNC_ADD, 3'd3, 3'd1, 3'd2, 32'd0, lat, a_o, b_o);
    chk("t2_res", res_out, 32'h8000_0000);
    chk("t2_ZNV", {29'd0, flag_Z, flag_N, flag_V}, 32'b011);
`ifdef ULA_STATS_EN
    chk("t2_op_count", {16'd0, op_count}, 32'd3);
    chk("t2_ovf_count", {16'd0, ovf_count}, 32'd1);
`endif

    // SUB r1-r1 gives zero
    issue(1'b1, FUNC_ADD, 3'd1, 3'd0, 3'd0, 32'h1234_5678, lat, a_o, b_o);
    issue(1'b0, FUNC_SUB, 3'd6, 3'd1, 3'd1, 32'd0, lat, a_o, b_o);
    chk("t3_exec_A", a_o, 32'h1234_5678);
    chk("t3_res", res_out, 32'd0);
    chk("t3_ZNV", {29'd0, flag_Z, flag_N, flag_V}, 32'b100);

    // Writes to r0 are dropped
    issue(1'b1, FUNC_ADD, 3'd0, 3'd0, 3'd0, 32'h0000_DEAD, lat, a_o, b_o);
    chk("t4_load_r0_res", res_out, 32'h0000_DEAD);
    issue(1'b0, FUNC_PASSA, 3'd4, 3'd0, 3'd1, 32'd0, lat, a_o, b_o);
    chk("t4_exec_A_r0", a_o, 32'd0);
    chk("t4_res", res_out, 32'd0);
    chk("t4_Z", {31'd0, flag_Z}, 32'd1);

    // AND with valid held high: one acceptance per IDLE visit
    issue(1'b1, FUNC_ADD, 3'd1, 3'd0, 3'd0, 32'h0000_F0F0, lat, a_o, b_o);
    issue(1'b1, FUNC_ADD, 3'd2, 3'd0, 3'd0, 32'h0000_FF00, lat, a_o, b_o);
    @(negedge clk);
    force_v = 1'b1;
    rif.req_load  = 1'b0;
    rif.req_func  = FUNC_AND;
    rif.req_rd    = 3'd5;
    rif.req_rs1   = 3'd1;
    rif.req_rs2   = 3'd2;
    rif.req_valid = 1'b1;
    acc = 0;
    dn  = 0;
    for (int i = 0; i < 6; i++) begin
      if (rif.req_ready) acc++;
      @(posedge clk); #1;
      if (done) dn++;
    end
    rif.req_valid = 1'b0;
    chk("t5_accepts", acc, 32'd2);
    chk("t5_dones", dn, 32'd2);
    chk("t5_res", res_out, 32'h0000_F000);
    chk("t5_V_forced", {31'd0, flag_V}, 32'd0);
    @(negedge clk);
    force_v = 1'b0;

    // Reset during EXEC of ADD r3 = r1 + r2
    @(negedge clk);
    rif.req_load  = 1'b0;
    rif.req_func  = FUNC_ADD;
    rif.req_rd    = 3'd3;
    rif.req_rs1   = 3'd1;
    rif.req_rs2   = 3'd2;
    rif.req_valid = 1'b1;
    @(posedge clk); #1;
    rif.req_valid = 1'b0;
    chk("t6_exec_A", ula_A, 32'h0000_F0F0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_ready", {31'd0, rif.req_ready}, 32'd1);
    chk("t6_res", res_out, 32'd0);
    chk("t6_ulaA", ula_A, 32'd0);
    chk("t6_flags", {29'd0, flag_Z, flag_N, flag_V}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_no_late_done", {31'd0, done}, 32'd0);
    issue(1'b0, FUNC_ADD, 3'd6, 3'd1, 3'd3, 32'd0, lat, a_o, b_o);
    chk("t6_r1_cleared", a_o, 32'd0);
    chk("t6_r3_cleared", b_o, 32'd0);
    chk("t6_post_lat", lat, 32'd2);
    chk("t6_post_Z", {31'd0, flag_Z}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ula_sequenciador.md
Name: ula_sequenciador

Overview:
Operand/control stage that sits directly upstream of the 32-bit ULA. It holds a small register file and accepts one operation request at a time over a valid/ready handshake. It drives the ULA operands A, B and func from registered values, samples R and pinV, writes the result back, and keeps Z/N/V flags. It turns the purely combinational ULA into a usable multi-cycle datapath.

Parameters:
DATA_W, 32, datapath width; must equal the ULA width.
NREGS, 8, number of registers; power of 2; register 0 is hardwired to zero.
ADDR_W, $clog2(NREGS), register address width (derived; do not override).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request (high only in IDLE).
req_load  input  1  1 = write req_imm to rd; 0 = ULA operation.
req_func  input  3  ULA function code (ignored when req_load=1).
req_rd  input  ADDR_W  destination register.
req_rs1  input  ADDR_W  source register driven on A.
req_rs2  input  ADDR_W  source register driven on B.
req_imm  input  DATA_W  immediate for load.
ula_A  output  DATA_W  registered operand A to ULA.
ula_B  output  DATA_W  registered operand B to ULA.
ula_func  output  3  registered function code to ULA.
ula_R  input  DATA_W  ULA result.
ula_pinV  input  1  ULA signed-overflow flag.
done  output  1  one-cycle pulse when write-back completes.
res_out  output  DATA_W  value written in the last write-back; held until the next one.
flag_Z  output  1  res_out == 0.
flag_N  output  1  res_out[DATA_W-1].
flag_V  output  1  overflow of the last arithmetic operation.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; all registers, ula_A/B/func, res_out, flags and done = 0.
  - Any in-flight operation is discarded, with no write-back.
  - rst_n takes priority over every other input.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture rd/load/imm.
  - Op (req_load=0): latch regs[rs1]→ula_A, regs[rs2]→ula_B, req_func→ula_func; go to EXEC.
  - Load (req_load=1): go to WB carrying imm; ula_A/B/func unchanged.
- EXEC: req_ready=0. ULA settles. At end of cycle, capture ula_R and ula_pinV into an internal result register; go to WB.
- WB:
  - req_ready=0. Write the result to regs[rd]; the write is suppressed if rd==0.
  - res_out = result. flag_Z/flag_N computed from the result.
  - flag_V = captured pinV when func ∈ {000,001}; otherwise 0; 0 for loads.
  - done=1 for this cycle only; go to IDLE.
- Latency: request accepted at edge T.
  - ULA op: done high in cycle T+2.
  - Load: done high in cycle T+1.
  - Throughput: one op per 3 cycles; one load per 2 cycles.
- req_valid while req_ready=0 is ignored; the requester must hold it until accepted.
- ula_A/B/func hold their last values outside EXEC and change only on op acceptance.
- Reads of rd written in the previous WB see the new value, because the write completes before the IDLE read.
- Register 0 always reads 0, including as rs1/rs2.
- Arithmetic is modulo 2^DATA_W; the block performs no arithmetic itself.

Optional Feature:
- Macro ULA_STATS_EN.
- When defined:
  - Adds output op_count[15:0]: incremented on every done.
  - Adds output ovf_count[15:0]: incremented on every done with flag_V=1.
  - Both counters saturate at 0xFFFF and clear on reset.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ula_pkg:
  - func constants FUNC_ADD=000, FUNC_SUB=001, FUNC_AND=010, FUNC_OR=011, FUNC_XNOR=100, FUNC_NOTA=101, FUNC_PASSA=110, FUNC_NOTB=111.
  - FSM state encoding: IDLE=0, EXEC=1, WB=2.
- Sub-module banco_registradores: NREGS×DATA_W, 2 combinational read ports, 1 synchronous write port, r0 hardwired zero, synchronous active-low clear.

Test Plan:
- Load r1=5, load r2=3, ADD rd=r3 → ula_A=5, ula_B=3 during EXEC; done at T+2; res_out=8; Z=0, N=0, V=0.
- Load r1=0x7FFFFFFF, r2=1, ADD → res_out=0x80000000, N=1, V=1; with ULA_STATS_EN, ovf_count=1 and op_count=3.
- SUB r1-r1 (r1=0x12345678) → res_out=0, Z=1, V=0.
- Load r0=0xDEAD, then PASSA rs1=0 into r4 → res_out=0, Z=1; r0 unchanged.
- Load r1=0xF0F0, r2=0xFF00, AND with req_valid held high throughout → exactly one acceptance per IDLE; res_out=0x0000F000; V=0 even if pinV forced 1.
- Assert rst_n=0 during EXEC of ADD r3=r1+r2 → no done, r3 stays 0; next cycle req_ready=1 and all outputs 0; r1 reads 0.
